// File: rtl/nibble_add_seq.sv
// Multi-precision adder: ripples a W-bit add through one shared 4-bit slice,
// one nibble per clock, least-significant nibble first, with start/busy/done handshake.
module nibble_add_seq #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [4*NIBBLES-1:0] a_i,
  input  logic [4*NIBBLES-1:0] b_i,
  input  logic                 cin_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [4*NIBBLES-1:0] sum_o,
  output logic                 cout_o
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q;
  logic [W-1:0]    op_a_q, op_b_q, sum_q;
  logic            carry_q, cout_q;
  logic [IdxW-1:0] idx_q;

  logic [3:0] nib_a, nib_b, nib_s;
  logic [4:0] nib_sum;
  logic       nib_c;

  // The single shared 4-bit adder slice.
  always_comb begin
    nib_a   = op_a_q[4*idx_q +: 4];
    nib_b   = op_b_q[4*idx_q +: 4];
    nib_sum = 5'(nib_a) + 5'(nib_b) + 5'(carry_q);
    nib_s   = nib_sum[3:0];
    nib_c   = nib_sum[4];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start_i) begin
            op_a_q  <= a_i;
            op_b_q  <= b_i;
            carry_q <= cin_i;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            state_q <= StRun;
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          sum_q[4*idx_q +: 4] <= nib_s;
          carry_q             <= nib_c;
          idx_q               <= idx_q + 1'b1;
          if (idx_q == LastIdx) begin
            cout_q  <= nib_c;
            state_q <= StDone;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);
  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq (NIBBLES=4): directed scenarios plus random
// operands checked against plain wide-integer arithmetic.
module tb_nibble_add_seq;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [15:0] a_i, b_i;
  logic        cin_i;
  logic        busy_o, done_o, cout_o;
  logic [15:0] sum_o;

  int checks   = 0;
  int failures = 0;

  nibble_add_seq #(.NIBBLES(4)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start_i(start_i),
    .a_i    (a_i),
    .b_i    (b_i),
    .cin_i  (cin_i),
    .busy_o (busy_o),
    .done_o (done_o),
    .sum_o  (sum_o),
    .cout_o (cout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Pulse start with the given operands, then wait (bounded) for done. Leaves the bench in
  // the done cycle. busy_cycles counts cycles with busy=1; lat is edges from acceptance.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int busy_cycles, output int lat, output logic seen);
    a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
    step();
    start_i = 1'b0;
    a_i = 16'hDEAD; b_i = 16'hBEEF; cin_i = 1'b1;
    lat = 1; busy_cycles = 0; seen = 1'b0;
    while (lat < 20) begin
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busy_cycles++;
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    int bc, lat;
    logic seen;
    rst_ni = 1'b0; start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, cout_o, sum_o} !== 19'h0) begin
      failures++;
      $display("FAIL reset_initial got busy=%b done=%b cout=%b sum=%h want all 0",
               busy_o, done_o, cout_o, sum_o);
    end
    #2 rst_ni = 1'b1;
    step();
    do_op(16'h7777, 16'h1111, 1'b1, bc, lat, seen);
    // Reset between clock edges must clear outputs without a clock.
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, cout_o, sum_o} !== 19'h0) begin
      failures++;
      $display("FAIL reset_async got busy=%b done=%b cout=%b sum=%h want all 0",
               busy_o, done_o, cout_o, sum_o);
    end
    @(negedge clk_i);
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_carry_ripple();
    int bc, lat;
    logic seen;
    do_op(16'hFFFF, 16'h0001, 1'b0, bc, lat, seen);
    checks++;
    if (!seen || lat != 5 || bc != 4) begin
      failures++;
      $display("FAIL ripple_timing got seen=%b lat=%0d busy=%0d want 1 5 4", seen, lat, bc);
    end
    checks++;
    if (sum_o !== 16'h0000 || cout_o !== 1'b1 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL ripple_result got sum=%h cout=%b busy=%b want 0000 1 0",
               sum_o, cout_o, busy_o);
    end
    step();
    checks++;
    if (done_o !== 1'b0 || sum_o !== 16'h0000 || cout_o !== 1'b1) begin
      failures++;
      $display("FAIL ripple_hold got done=%b sum=%h cout=%b want 0 0000 1",
               done_o, sum_o, cout_o);
    end
  endtask

  task automatic test_carry_in();
    int n;
    a_i = 16'h1234; b_i = 16'h4321; cin_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0;
    step();
    step();
    checks++;
    if (sum_o !== 16'h0056 || cout_o !== 1'b0 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL cin_partial got sum=%h cout=%b busy=%b want 0056 0 1",
               sum_o, cout_o, busy_o);
    end
    n = 0;
    while (!done_o && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (n != 2 || sum_o !== 16'h5556 || cout_o !== 1'b0) begin
      failures++;
      $display("FAIL cin_result got wait=%0d sum=%h cout=%b want 2 5556 0", n, sum_o, cout_o);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int n, extra;
    a_i = 16'h00FF; b_i = 16'h0001; cin_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    a_i = 16'hFFFF; b_i = 16'hFFFF; start_i = 1'b1;
    step();
    start_i = 1'b0;
    n = 0;
    while (!done_o && n < 10) begin
      step();
      n++;
    end
    checks++;
    if (!done_o || sum_o !== 16'h0100 || cout_o !== 1'b0) begin
      failures++;
      $display("FAIL ignore_result got done=%b sum=%h cout=%b want 1 0100 0",
               done_o, sum_o, cout_o);
    end
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done_o || busy_o) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL ignore_no_second got %0d active cycles want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    a_i = 16'h8000; b_i = 16'h8000; cin_i = 1'b0; start_i = 1'b1;
    step();
    a_i = 16'h0001; b_i = 16'h0002; cin_i = 1'b0;
    lat = 1;
    while (!done_o && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (!done_o || lat != 5 || sum_o !== 16'h0000 || cout_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first got done=%b lat=%0d sum=%h cout=%b want 1 5 0000 1",
               done_o, lat, sum_o, cout_o);
    end
    step();
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_rebusy got busy=%b done=%b want 1 0", busy_o, done_o);
    end
    lat = 1;
    while (!done_o && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (!done_o || lat != 5 || sum_o !== 16'h0003 || cout_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got done=%b lat=%0d sum=%h cout=%b want 1 5 0003 0",
               done_o, lat, sum_o, cout_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int bc, lat, extra;
    logic seen;
    a_i = 16'h1234; b_i = 16'h1111; cin_i = 1'b0; start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, done_o, cout_o, sum_o} !== 19'h0) begin
      failures++;
      $display("FAIL midreset_clear got busy=%b done=%b cout=%b sum=%h want all 0",
               busy_o, done_o, cout_o, sum_o);
    end
    step();
    @(negedge clk_i);
    rst_ni = 1'b1;
    extra = 0;
    for (int i = 0; i < 7; i++) begin
      step();
      if (done_o || busy_o) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL midreset_no_done got %0d active cycles want 0", extra);
    end
    do_op(16'h000A, 16'h0005, 1'b0, bc, lat, seen);
    checks++;
    if (!seen || lat != 5 || sum_o !== 16'h000F || cout_o !== 1'b0) begin
      failures++;
      $display("FAIL midreset_after got seen=%b lat=%0d sum=%h cout=%b want 1 5 000F 0",
               seen, lat, sum_o, cout_o);
    end
    step();
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic        c;
    logic [16:0] full, mask;
    for (int t = 0; t < 40; t++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      if (t == 0) begin a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; end
      full = 17'(a) + 17'(b) + 17'(c);
      a_i = a; b_i = b; cin_i = c; start_i = 1'b1;
      step();
      start_i = 1'($urandom);
      a_i = 16'($urandom); b_i = 16'($urandom); cin_i = 1'($urandom);
      // Only the low 4*j bits of the true sum are visible after j nibble steps.
      for (int j = 1; j < 4; j++) begin
        step();
        mask = (17'h1 << (4 * j)) - 17'h1;
        checks++;
        if (busy_o !== 1'b1 || 17'(sum_o) !== (full & mask) || cout_o !== 1'b0) begin
          failures++;
          $display("FAIL rand_partial t=%0d j=%0d got busy=%b sum=%h cout=%b want 1 %h 0",
                   t, j, busy_o, sum_o, cout_o, 16'(full & mask));
        end
      end
      start_i = 1'b0;
      step();
      checks++;
      if (done_o !== 1'b1 || busy_o !== 1'b0 || {cout_o, sum_o} !== full) begin
        failures++;
        $display("FAIL rand_final t=%0d got done=%b cout=%b sum=%h want 1 %b %h",
                 t, done_o, cout_o, sum_o, full[16], full[15:0]);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_carry_in();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_add_seq.md
# nibble_add_seq

Multi-precision add sequencer. Adds two NIBBLES×4-bit operands using a single shared 4-bit adder slice, one nibble per clock, least-significant nibble first, with the carry held in a register between nibbles. It sits between a requester issuing wide additions and the 4-bit adder datapath, and uses a start/busy/done handshake.

## Interface
- NIBBLES, 4, number of 4-bit slices per operand (≥2); operand width W = 4×NIBBLES

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled on rising clk
- a  input  W  operand A; sampled only on the accepting edge
- b  input  W  operand B; sampled only on the accepting edge
- cin  input  1  carry-in to nibble 0; sampled only on the accepting edge
- busy  output  1  high while the addition is in progress (RUN state)
- done  output  1  one-cycle pulse; sum/cout valid
- sum  output  W  result register
- cout  output  1  carry out of the top nibble

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE.
- Registers: op_a, op_b (W bits), carry (1), idx (ceil(log2 NIBBLES) bits, minimum 1), sum, cout.
- IDLE or DONE with start=1: latch a→op_a, b→op_b, cin→carry, idx←0, sum←0, cout←0; go to RUN.
- IDLE with start=0: hold. DONE with start=0: go to IDLE.
- RUN, each edge: compute {c4,s4} = op_a[idx] + op_b[idx] + carry (4-bit + 4-bit + 1, 5-bit result); sum[4·idx+3:4·idx]←s4; carry←c4; idx←idx+1.
- RUN when idx = NIBBLES−1: same nibble step, plus cout←c4; go to DONE.
- start while in RUN: ignored; no relatch and no queueing. a, b, and cin may change freely after acceptance.
- Arithmetic: {cout,sum} = a + b + cin modulo 2^(W+1). No overflow flag.
- Outputs: busy = (state==RUN), done = (state==DONE), both decoded from the state register with no combinational path from inputs.
- sum and cout hold their last value in IDLE and DONE until the next accepted start.

## Timing
- Reset (rst_n=0, any time, including mid-RUN): state IDLE and all registers cleared immediately, without a clock. busy=0, done=0, sum=0, cout=0. The in-flight operation is discarded.
- Reset release: first accepting edge is the first rising clk with rst_n=1 and start=1.
- Acceptance on edge k: busy=1 from after edge k through edge k+NIBBLES.
- Nibble i is written on edge k+1+i.
- done=1 for exactly the cycle after edge k+NIBBLES. Final sum and cout are valid in that same cycle.
- Latency from the accepting edge to done: NIBBLES+1 edges (5 for the default).
- Throughput: start held high in DONE gives back-to-back operations, one per NIBBLES+1 cycles. done still pulses for one cycle, and busy rises on the next edge.
- During RUN, sum shows a partial result: nibbles not yet written read 0, and cout reads 0.

## Test plan
- Reset values: assert rst_n=0 mid-cycle without a clock → busy=0, done=0, sum=0, cout=0 immediately.
- Carry ripple: NIBBLES=4, a=16'hFFFF, b=16'h0001, cin=0, start pulse → busy high 4 cycles, then done 1 cycle, sum=16'h0000, cout=1, done on edge 5 after acceptance.
- Carry-in, no carry-out: a=16'h1234, b=16'h4321, cin=1 → sum=16'h5556, cout=0. Mid-run check: after edge 2, sum=16'h0056.
- Start ignored while busy: accept a=16'h00FF, b=16'h0001, then pulse start with a=16'hFFFF, b=16'hFFFF during RUN → result sum=16'h0100, cout=0; no second done.
- Back-to-back: hold start=1 across two operations (8000+8000, then 0001+0002) → first done with sum=16'h0000, cout=1; busy rises next edge; second done 5 cycles later with sum=16'h0003, cout=0.
- Reset mid-operation: drop rst_n after 2 RUN edges → outputs clear at once and no done follows. After release with start=1 and a=16'h000A, b=16'h0005 → sum=16'h000F, cout=0.
